cordic_vec_pipe: RTL and testbench

Fully pipelined, parametrised CORDIC vectoring engine that converts signed gradient pairs (dx, dy) into magnitude and full-circle angle for the SIFT orientation-histogram and descriptor stages. It handles all four quadrants with a pre-rotation stage, applies optional CORDIC gain compensation, and supports valid/ready backpressure with a global pipeline stall. It accepts one sample per cycle.

---
 rtl/cordic_vec_pipe_if.sv | 25 ++
 rtl/cordic_vec_pipe.sv | 159 +++++++++++++++
 tb/tb_cordic_vec_pipe.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_vec_pipe_if.sv
// Sample/result handshake bundle for the CORDIC vectoring pipe.
// Upstream sample and downstream result share one interface.
interface cordic_vec_pipe_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_x;
  logic [DW-1:0] in_y;
  logic          out_valid;
  logic          out_ready;
  logic [DW+1:0] out_mag;
  logic [AW-1:0] out_ang;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_mag, out_ang
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_mag, out_ang
  );
endinterface

// File: rtl/cordic_vec_pipe.sv
// Pipelined CORDIC vectoring: (dx,dy) -> magnitude, full-turn angle.
// One global enable freezes every stage while the output is held.
module cordic_vec_pipe #(
  parameter int DW        = 16,
  parameter int AW        = 16,
  parameter int ITER      = 14,
  parameter int GUARD     = 4,
  parameter int GAIN_COMP = 1
) (
  input logic              clk,
  input logic              rst,
  cordic_vec_pipe_if.slave bus
);
  localparam int IW = DW + 3 + GUARD;
  localparam int N  = ITER + 1;
  localparam int PW = IW + 17;
  localparam int GK = 39797;

  localparam logic [AW-1:0] Q1 = AW'(1) << (AW - 2);
  localparam logic [AW-1:0] Q3 = AW'(3) << (AW - 2);

  // atan(2^-i) as a fraction of a turn, scaled to 2^32
  localparam logic [31:0] ATAN32 [32] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
  };

  function automatic logic [ITER*AW-1:0] build_tbl();
    logic [ITER*AW-1:0] t;
    logic [32:0]        r;
    t = '0;
    for (int i = 0; i < ITER; i++) begin
      r = {1'b0, ATAN32[i]};
      if (AW < 32) r = r + (33'd1 << (31 - AW));
      r = r >> (32 - AW);
      t[i*AW +: AW] = r[AW-1:0];
    end
    return t;
  endfunction

  localparam logic [ITER*AW-1:0] ATAN = build_tbl();

  function automatic logic [DW+1:0] gain_mag(
    input logic signed [IW-1:0] x
  );
    logic signed [PW-1:0] p;
    p = PW'(x) * PW'(GK);
    return p[16+GUARD +: DW+2];
  endfunction

  logic                 en;
  logic                 xneg;
  logic                 yneg;
  logic signed [IW-1:0] xin;
  logic signed [IW-1:0] yin;
  logic signed [IW-1:0] xs [N];
  logic signed [IW-1:0] ys [N];
  logic [AW-1:0]        zs [N];
  logic                 vs [N];
  logic                 zf [N];
  logic [DW+1:0]        fm;
  logic [AW-1:0]        fz;
  logic                 fv;
  logic                 fzf;

  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;
  assign xneg         = bus.in_x[DW-1];
  assign yneg         = bus.in_y[DW-1];
  assign xin = {{(IW-DW){bus.in_x[DW-1]}}, bus.in_x} <<< GUARD;
  assign yin = {{(IW-DW){bus.in_y[DW-1]}}, bus.in_y} <<< GUARD;

  // quadrant pre-rotation followed by ITER micro-rotations
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        xs[i] <= '0;
        ys[i] <= '0;
        zs[i] <= '0;
        vs[i] <= 1'b0;
        zf[i] <= 1'b0;
      end
    end else if (en) begin
      vs[0] <= bus.in_valid;
      zf[0] <= (bus.in_x == '0) && (bus.in_y == '0);
      unique case (1'b1)
        !xneg: begin
          xs[0] <= xin;
          ys[0] <= yin;
          zs[0] <= '0;
        end
        xneg && !yneg: begin
          xs[0] <= yin;
          ys[0] <= -xin;
          zs[0] <= Q1;
        end
        xneg && yneg: begin
          xs[0] <= -yin;
          ys[0] <= xin;
          zs[0] <= Q3;
        end
      endcase
      for (int i = 0; i < ITER; i++) begin
        vs[i+1] <= vs[i];
        zf[i+1] <= zf[i];
        if (!ys[i][IW-1]) begin
          xs[i+1] <= xs[i] + (ys[i] >>> i);
          ys[i+1] <= ys[i] - (xs[i] >>> i);
          zs[i+1] <= zs[i] + ATAN[i*AW +: AW];
        end else begin
          xs[i+1] <= xs[i] - (ys[i] >>> i);
          ys[i+1] <= ys[i] + (xs[i] >>> i);
          zs[i+1] <= zs[i] - ATAN[i*AW +: AW];
        end
      end
    end
  end

  if (GAIN_COMP != 0) begin : g_gain
    // scale by 1/K and drop guard bits in one registered step
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        fm  <= '0;
        fz  <= '0;
        fv  <= 1'b0;
        fzf <= 1'b0;
      end else if (en) begin
        fm  <= gain_mag(xs[ITER]);
        fz  <= zs[ITER];
        fv  <= vs[ITER];
        fzf <= zf[ITER];
      end
    end
  end else begin : g_raw
    assign fm  = xs[ITER][GUARD +: DW+2];
    assign fz  = zs[ITER];
    assign fv  = vs[ITER];
    assign fzf = zf[ITER];
  end

  // output register; a zero vector reports 0 magnitude and angle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid <= 1'b0;
      bus.out_mag   <= '0;
      bus.out_ang   <= '0;
    end else if (en) begin
      bus.out_valid <= fv;
      bus.out_mag   <= fzf ? '0 : fm;
      bus.out_ang   <= fzf ? '0 : fz;
    end
  end
endmodule

// File: tb/tb_cordic_vec_pipe.sv
// Scoreboard bench for cordic_vec_pipe: default build plus
// an ITER=8, uncompensated build sharing clock and reset.
module tb_cordic_vec_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cordic_vec_pipe_if #(.DW(16), .AW(16)) b1 ();
  cordic_vec_pipe_if #(.DW(16), .AW(16)) b2 ();

  cordic_vec_pipe #(
    .DW(16), .AW(16), .ITER(14), .GUARD(4), .GAIN_COMP(1)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );

  cordic_vec_pipe #(
    .DW(16), .AW(16), .ITER(8), .GUARD(4), .GAIN_COMP(0)
  ) dut2 (
    .clk(clk), .rst(rst), .bus(b2.slave)
  );

  typedef struct {
    int mag;
    int ang;
    int mtol;
    int atol;
    bit lat;
    int cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t cur1;
  exp_t cur2;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   hold [3];
  int   hm [3];
  int   ha [3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got,
                     input int want, input int tol);
    checks++;
    if (got - want > tol || want - got > tol) begin
      errors++;
      $display("FAIL %s got %0d want %0d tol %0d",
               nm, got, want, tol);
    end
  endtask

  task automatic chk_ang(input string nm, input int got,
                         input int want, input int tol);
    int d;
    d = (got - want) & 65535;
    if (d > 32767) d = d - 65536;
    checks++;
    if (d > tol || -d > tol) begin
      errors++;
      $display("FAIL %s got %0d want %0d tol %0d",
               nm, got, want, tol);
    end
  endtask

  task automatic observe(input int d, input logic iv,
                         input logic ir, input logic ov,
                         input logic ordy, input int mag,
                         input int ang);
    exp_t e;
    if (!rst) begin
      hold[d] = 1'b0;
      return;
    end
    if (iv && ir) begin
      e = (d == 1) ? cur1 : cur2;
      e.cyc = cyc;
      if (d == 1) q1.push_back(e);
      else q2.push_back(e);
    end
    if (hold[d]) begin
      chk($sformatf("hold_valid%0d", d), int'(ov), 1, 0);
      chk($sformatf("hold_mag%0d", d), mag, hm[d], 0);
      chk($sformatf("hold_ang%0d", d), ang, ha[d], 0);
    end
    if (ov && !ordy)
      chk($sformatf("stall_in_ready%0d", d), int'(ir), 0, 0);
    hold[d] = ov && !ordy;
    hm[d] = mag;
    ha[d] = ang;
    if (ov && ordy) begin
      if ((d == 1 && q1.size() == 0) ||
          (d == 2 && q2.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out%0d got mag %0d ang %0d want none",
                 d, mag, ang);
      end else begin
        if (d == 1) e = q1.pop_front();
        else e = q2.pop_front();
        chk($sformatf("mag%0d", d), mag, e.mag, e.mtol);
        chk_ang($sformatf("ang%0d", d), ang, e.ang, e.atol);
        if (e.lat)
          chk($sformatf("latency%0d", d), cyc - e.cyc,
              (d == 1) ? 17 : 10, 0);
      end
    end
  endtask

  // monitor both DUTs well after the drivers settle
  always @(negedge clk) begin
    #2;
    observe(1, b1.in_valid, b1.in_ready, b1.out_valid,
            b1.out_ready, int'(b1.out_mag), int'(b1.out_ang));
    observe(2, b2.in_valid, b2.in_ready, b2.out_valid,
            b2.out_ready, int'(b2.out_mag), int'(b2.out_ang));
  end

  task automatic send(input int d, input int x, input int y,
                      input int mag, input int ang,
                      input int mtol, input int atol,
                      input bit lat);
    exp_t e;
    int n;
    logic ir;
    e.mag = mag; e.ang = ang;
    e.mtol = mtol; e.atol = atol;
    e.lat = lat; e.cyc = 0;
    if (d == 1) begin
      cur1 = e;
      b1.in_valid = 1'b1;
      b1.in_x = 16'(x);
      b1.in_y = 16'(y);
    end else begin
      cur2 = e;
      b2.in_valid = 1'b1;
      b2.in_x = 16'(x);
      b2.in_y = 16'(y);
    end
    n = 0;
    forever begin
      #3;
      ir = (d == 1) ? b1.in_ready : b2.in_ready;
      @(negedge clk);
      if (ir) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout%0d got stalled want accept", d);
        break;
      end
    end
  endtask

  task automatic idle();
    b1.in_valid = 1'b0;
    b2.in_valid = 1'b0;
  endtask

  task automatic model(input int x, input int y,
                       output int mag, output int ang);
    real r;
    real a;
    r = $sqrt(real'(x) * x + real'(y) * y);
    a = $atan2(real'(y), real'(x)) * 65536.0 /
        (2.0 * 3.14159265358979);
    if (a < 0.0) a = a + 65536.0;
    mag = int'(r);
    ang = int'(a) % 65536;
  endtask

  task automatic send_rand(input bit lat);
    int x;
    int y;
    int m;
    int a;
    do begin
      x = int'($urandom_range(0, 65535)) - 32768;
      y = int'($urandom_range(0, 65535)) - 32768;
    end while (x > -8192 && x < 8192 && y > -8192 && y < 8192);
    model(x, y, m, a);
    send(1, x, y, m, a, m / 1000 + 2, 4, lat);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending want 0/0",
               q1.size(), q2.size());
    end
  endtask

  int tx [12] = '{1000, 0, -1000, 0, -32768, 32767,
                  0, 1000, 3000, -3000, -4000, 3000};
  int ty [12] = '{0, 1000, 0, -1000, -32768, -32768,
                  0, -1, 4000, 4000, -3000, -4000};
  int tm [12] = '{1000, 1000, 1000, 1000, 46341, 46340,
                  0, 1000, 5000, 5000, 5000, 5000};
  int ta [12] = '{0, 16384, 32768, 49152, 40960, 57344,
                  0, 65526, 9672, 23096, 39480, 55864};
  int tt [12] = '{2, 2, 2, 2, 48, 48, 0, 2, 7, 7, 7, 7};

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog got timeout want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    b1.in_valid = 1'b0; b1.in_x = '0; b1.in_y = '0;
    b2.in_valid = 1'b0; b2.in_x = '0; b2.in_y = '0;
    b1.out_ready = 1'b1;
    b2.out_ready = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(b1.out_valid), 0, 0);
    chk("rst_out_mag", int'(b1.out_mag), 0, 0);
    chk("rst_out_ang", int'(b1.out_ang), 0, 0);
    chk("rst_in_ready", int'(b1.in_ready), 1, 0);
    rst = 1'b1;

    for (int i = 0; i < 12; i++)
      send(1, tx[i], ty[i], tm[i], ta[i], tt[i],
           (tm[i] == 0) ? 0 : 4, i == 0);
    idle();
    drain();

    for (int i = 0; i < 200; i++) send_rand(i == 0);
    idle();
    drain();

    fork
      begin
        for (int i = 0; i < 30; i++) send_rand(1'b0);
        idle();
      end
      begin
        repeat (20) @(negedge clk);
        b1.out_ready = 1'b0;
        repeat (5) @(negedge clk);
        b1.out_ready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 10; i++) send_rand(1'b0);
    idle();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", int'(b1.out_valid), 0, 0);
    chk("midrst_out_mag", int'(b1.out_mag), 0, 0);
    q1.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("postrst_in_ready", int'(b1.in_ready), 1, 0);
    send(1, 0, 1000, 1000, 16384, 2, 4, 1'b1);
    idle();
    repeat (30) @(negedge clk);
    drain();

    send(2, 1000, 0, 1647, 0, 4, 100, 1'b1);
    send(2, 0, -1000, 1647, 49152, 4, 100, 1'b0);
    send(2, 3000, 4000, 8234, 9672, 10, 100, 1'b0);
    send(2, -32768, -32768, 76312, 40960, 78, 100, 1'b0);
    send(2, 0, 0, 0, 0, 0, 0, 1'b0);
    idle();
    drain();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
